// File: rtl/conv_viterbi_pkg.sv
// Shared types and helpers for the BER test controller around the Viterbi datapath.
// Holds the word width, counter width, FSM state encoding and the popcount helper.
package conv_viterbi_pkg;

  localparam int WORD_W = 16;
  localparam int CNT_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Number of set bits in a word, returned at counter width so it adds directly.
  function automatic logic [CNT_W-1:0] popcount(input logic [WORD_W-1:0] w);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < WORD_W; i++) begin
      n = n + {{(CNT_W-1){1'b0}}, w[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/ber_test_ctrl_if.sv
// Control/status bundle between the BER test controller and its environment.
// master = stimulus/decoder side, slave = ber_test_ctrl.
interface ber_test_ctrl_if #(
  parameter int WORD_W = 16
);
  logic              start;
  logic              abort;
  logic [WORD_W-1:0] src_word;
  logic [WORD_W-1:0] dec_word;
  logic              clk_enable;
  logic              busy;
  logic              done;
  logic [31:0]       word_cnt;
  logic [31:0]       err_cnt;
  logic              err_sat;

  modport master (
    output start, abort, src_word, dec_word,
    input  clk_enable, busy, done, word_cnt, err_cnt, err_sat
  );

  modport slave (
    input  start, abort, src_word, dec_word,
    output clk_enable, busy, done, word_cnt, err_cnt, err_sat
  );
endinterface

// File: rtl/word_delay_line.sv
// Data-plus-valid shift register that models the encoder/decoder latency.
// Advances only when enabled; clr empties it synchronously.
module word_delay_line #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid
);
  logic [WIDTH-1:0] data_r [DEPTH];
  logic [DEPTH-1:0] valid_r;

  // Shift stages toward the output on each enabled cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_r <= '0;
      for (int i = 0; i < DEPTH; i++) data_r[i] <= '0;
    end else if (clr) begin
      valid_r <= '0;
      for (int i = 0; i < DEPTH; i++) data_r[i] <= '0;
    end else if (en) begin
      data_r[0]  <= in_data;
      valid_r[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        data_r[i]  <= data_r[i-1];
        valid_r[i] <= valid_r[i-1];
      end
    end else begin
      valid_r <= valid_r;
    end
  end

  assign out_data  = data_r[DEPTH-1];
  assign out_valid = valid_r[DEPTH-1];
endmodule

// File: rtl/ber_test_ctrl.sv
// BER test controller: gates the noise/encoder/decoder chain for one frame and counts bit errors.
// Define ERR_SATURATE_EN to make err_cnt clamp at all-ones and raise err_sat instead of wrapping.
module ber_test_ctrl
  import conv_viterbi_pkg::state_t, conv_viterbi_pkg::ST_IDLE, conv_viterbi_pkg::ST_RUN,
         conv_viterbi_pkg::ST_DRAIN, conv_viterbi_pkg::ST_DONE, conv_viterbi_pkg::CNT_W,
         conv_viterbi_pkg::popcount;
#(
  parameter int FRAME_WORDS = 64,
  parameter int LATENCY     = 32,
  parameter int WORD_W      = conv_viterbi_pkg::WORD_W
) (
  input  logic             clk,
  input  logic             reset,
  ber_test_ctrl_if.slave   bus
);
  state_t            state_r, state_nxt_s;
  logic [15:0]       phase_r;
  logic              accept_s, last_run_s, last_drain_s;
  logic              en_nxt_s, busy_nxt_s, done_nxt_s;
  logic              clk_enable_r, busy_r, done_r;
  logic [CNT_W-1:0]  word_cnt_r, err_cnt_r, err_add_s;
  logic [CNT_W:0]    sum_s;
  logic              err_sat_r;
  logic [WORD_W-1:0] dly_data_s;
  logic              dly_valid_s;

  assign accept_s     = (state_r == ST_IDLE) && bus.start && !bus.abort;
  assign last_run_s   = (phase_r == 16'(FRAME_WORDS - 1));
  assign last_drain_s = (phase_r == 16'(LATENCY - 1));

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Next-state logic; abort outranks both start and the phase counter.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:  if (accept_s) state_nxt_s = ST_RUN;   else state_nxt_s = ST_IDLE;
      ST_RUN:   if (bus.abort) state_nxt_s = ST_IDLE;
                else if (last_run_s) state_nxt_s = ST_DRAIN;
                else state_nxt_s = ST_RUN;
      ST_DRAIN: if (bus.abort) state_nxt_s = ST_IDLE;
                else if (last_drain_s) state_nxt_s = ST_DONE;
                else state_nxt_s = ST_DRAIN;
      ST_DONE:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they can be registered in step with it.
  always_comb begin
    en_nxt_s   = (state_nxt_s == ST_RUN) || (state_nxt_s == ST_DRAIN);
    busy_nxt_s = (state_nxt_s != ST_IDLE);
    done_nxt_s = (state_nxt_s == ST_DONE);
  end

  // Output register and per-state cycle counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_enable_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      phase_r      <= 16'd0;
    end else begin
      clk_enable_r <= en_nxt_s;
      busy_r       <= busy_nxt_s;
      done_r       <= done_nxt_s;
      phase_r      <= (state_nxt_s != state_r) ? 16'd0 : phase_r + 16'd1;
    end
  end

  word_delay_line #(.DEPTH(LATENCY), .WIDTH(WORD_W)) u_dly (
    .clk       (clk),
    .reset     (reset),
    .clr       (accept_s),
    .en        (clk_enable_r),
    .in_data   (bus.src_word),
    .in_valid  (state_r == ST_RUN),
    .out_data  (dly_data_s),
    .out_valid (dly_valid_s)
  );

  assign err_add_s = popcount(dly_data_s ^ bus.dec_word);
  assign sum_s     = {1'b0, err_cnt_r} + {1'b0, err_add_s};

  // Word/error accumulation; counters hold whenever no valid word is compared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_cnt_r <= '0;
      err_cnt_r  <= '0;
      err_sat_r  <= 1'b0;
    end else if (accept_s) begin
      word_cnt_r <= '0;
      err_cnt_r  <= '0;
      err_sat_r  <= 1'b0;
    end else if (clk_enable_r && dly_valid_s) begin
      word_cnt_r <= word_cnt_r + 32'd1;
`ifdef ERR_SATURATE_EN
      if (sum_s[CNT_W]) begin
        err_cnt_r <= {CNT_W{1'b1}};
        err_sat_r <= 1'b1;
      end else begin
        err_cnt_r <= sum_s[CNT_W-1:0];
      end
`else
      err_cnt_r <= sum_s[CNT_W-1:0];
`endif
    end else begin
      word_cnt_r <= word_cnt_r;
    end
  end

  assign bus.clk_enable = clk_enable_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.word_cnt   = word_cnt_r;
  assign bus.err_cnt    = err_cnt_r;
  assign bus.err_sat    = err_sat_r;
endmodule

// File: tb/tb_ber_test_ctrl.sv
// Self-checking bench for ber_test_ctrl with FRAME_WORDS=8, LATENCY=4.
// The decoder is modelled as a 4-enable-cycle delay of src_word XOR an error mask.
module tb_ber_test_ctrl;
  localparam int FW  = 8;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ber_test_ctrl_if #(.WORD_W(16)) bus();

  ber_test_ctrl #(.FRAME_WORDS(FW), .LATENCY(LAT), .WORD_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [15:0] hist [LAT];
  logic [15:0] err_mask = 16'h0000;
  assign bus.dec_word = hist[LAT-1] ^ err_mask;

  // Decoder model: advances only while the chain is enabled.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LAT; i++) hist[i] <= 16'h0000;
    end else if (bus.clk_enable) begin
      hist[0] <= bus.src_word;
      for (int i = 1; i < LAT; i++) hist[i] <= hist[i-1];
    end
  end

  typedef struct {
    logic [31:0] words;
    logic [31:0] errs;
    int          ens;
    logic        sat;
  } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  task automatic tick();
    @(negedge clk);
    bus.src_word = 16'($urandom);
  endtask

  task automatic run_frame(input int start_at, input int force_at, output int ens, output bit done_ok);
    bit prev_en;
    ens = 0; done_ok = 1'b0; prev_en = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int t = 1; t <= 60; t++) begin
      if (bus.done) begin
        done_ok = prev_en && !bus.clk_enable;
        break;
      end
      if (bus.clk_enable) ens++;
      prev_en = bus.clk_enable;
      bus.start = (t == start_at);
      if (t == force_at) force dut.err_cnt_r = 32'hFFFF_FFF0;
      if (t == force_at + 1) release dut.err_cnt_r;
      tick();
    end
    bus.start = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    total++; if (bus.clk_enable !== 1'b0) begin bad++; $display("FAIL reset_en got=%b want=0", bus.clk_enable); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
    total++; if (bus.word_cnt !== 32'd0) begin bad++; $display("FAIL reset_words got=%0d want=0", bus.word_cnt); end
    total++; if (bus.err_cnt !== 32'd0) begin bad++; $display("FAIL reset_errs got=%0d want=0", bus.err_cnt); end
    total++; if (bus.err_sat !== 1'b0) begin bad++; $display("FAIL reset_sat got=%b want=0", bus.err_sat); end
  endtask

  task automatic test_frame(input string name, input logic [15:0] mask, input int start_at);
    int ens; bit dok; exp_t e;
    err_mask = mask;
    exp_q.push_back('{words: 32'(FW), errs: 32'($countones(mask) * FW), ens: FW + LAT, sat: 1'b0});
    run_frame(start_at, -10, ens, dok);
    e = exp_q.pop_front();
    total++; if (ens !== e.ens) begin bad++; $display("FAIL %s_enables got=%0d want=%0d", name, ens, e.ens); end
    total++; if (dok !== 1'b1) begin bad++; $display("FAIL %s_done got=%b want=1", name, dok); end
    total++; if (bus.word_cnt !== e.words) begin bad++; $display("FAIL %s_words got=%0d want=%0d", name, bus.word_cnt, e.words); end
    total++; if (bus.err_cnt !== e.errs) begin bad++; $display("FAIL %s_errs got=%0d want=%0d", name, bus.err_cnt, e.errs); end
    total++; if (bus.err_sat !== e.sat) begin bad++; $display("FAIL %s_sat got=%b want=%b", name, bus.err_sat, e.sat); end
  endtask

  task automatic test_abort();
    exp_t e; bit saw_done;
    err_mask = 16'h0101;
    exp_q.push_back('{words: 32'd1, errs: 32'd2, ens: 0, sat: 1'b0});
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    for (int t = 1; t < 5; t++) tick();
    bus.abort = 1'b1; tick(); bus.abort = 1'b0;
    e = exp_q.pop_front();
    total++; if (bus.clk_enable !== 1'b0) begin bad++; $display("FAIL abort_en got=%b want=0", bus.clk_enable); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", bus.busy); end
    saw_done = bus.done;
    for (int t = 0; t < 6; t++) begin tick(); saw_done |= bus.done; end
    total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b want=0", saw_done); end
    total++; if (bus.word_cnt !== e.words) begin bad++; $display("FAIL abort_words got=%0d want=%0d", bus.word_cnt, e.words); end
    total++; if (bus.err_cnt !== e.errs) begin bad++; $display("FAIL abort_errs got=%0d want=%0d", bus.err_cnt, e.errs); end
  endtask

  task automatic test_saturate();
    int ens; bit dok; exp_t e;
    err_mask = 16'hFFFF;
`ifdef ERR_SATURATE_EN
    exp_q.push_back('{words: 32'(FW), errs: 32'hFFFF_FFFF, ens: FW + LAT, sat: 1'b1});
`else
    exp_q.push_back('{words: 32'(FW), errs: 32'h0000_0070, ens: FW + LAT, sat: 1'b0});
`endif
    run_frame(-10, 2, ens, dok);
    e = exp_q.pop_front();
    total++; if (bus.err_cnt !== e.errs) begin bad++; $display("FAIL sat_errs got=%h want=%h", bus.err_cnt, e.errs); end
    total++; if (bus.err_sat !== e.sat) begin bad++; $display("FAIL sat_flag got=%b want=%b", bus.err_sat, e.sat); end
    total++; if (bus.word_cnt !== e.words) begin bad++; $display("FAIL sat_words got=%0d want=%0d", bus.word_cnt, e.words); end
  endtask

  task automatic test_reset_in_drain();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    for (int t = 1; t < 10; t++) tick();
    reset = 1'b0;
    #1;
    total++;
    if ({bus.clk_enable, bus.busy, bus.done, bus.err_sat, bus.word_cnt, bus.err_cnt} !== 68'd0) begin
      bad++;
      $display("FAIL drain_reset got en=%b busy=%b done=%b sat=%b words=%0d errs=%0d want all zero",
               bus.clk_enable, bus.busy, bus.done, bus.err_sat, bus.word_cnt, bus.err_cnt);
    end
    tick(); tick();
    reset = 1'b1;
    tick();
    test_frame("post_reset", 16'h0000, -10);
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.src_word = 16'h0000;
    tick(); tick();
    test_reset();
    reset = 1'b1;
    tick();
    test_frame("loopback", 16'h0000, -10);
    test_frame("errors", 16'h0003, -10);
    test_abort();
    test_frame("start_in_run", 16'h8000, 3);
    test_saturate();
    test_reset_in_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ber_test_ctrl.md
BER_TEST_CTRL -- requirements
Module: ber_test_ctrl

Interface
REQ-001 The block SHALL provide parameter FRAME_WORDS, default 64: number of source words injected per test frame (1..65535).
REQ-002 The block SHALL provide parameter LATENCY, default 32: encoder-plus-decoder latency in enabled cycles (1..255).
REQ-003 The block SHALL provide parameter WORD_W, default 16: width of the source and decoded words.
REQ-004 Port: clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-low reset.
REQ-006 Port: start  input  1  one-cycle pulse that begins a frame; accepted only in IDLE.
REQ-007 Port: abort  input  1  level; terminates a frame in progress.
REQ-008 Port: src_word  input  WORD_W  word currently driven by the noise source into the encoder.
REQ-009 Port: dec_word  input  WORD_W  word from the Viterbi decoder output.
REQ-010 Port: clk_enable  output  1  shared enable to noise source, encoder and decoder.
REQ-011 Port: busy  output  1  high in any state other than IDLE.
REQ-012 Port: done  output  1  one-cycle pulse when a frame completes normally.
REQ-013 Port: word_cnt  output  32  number of words compared in the last or current frame.
REQ-014 Port: err_cnt  output  32  accumulated bit errors in the last or current frame.
REQ-015 Port: err_sat  output  1  error counter saturation flag.

Function
REQ-016 FSM states SHALL be IDLE, RUN, DRAIN and DONE, with IDLE as the reset state.
REQ-017 In IDLE, a start pulse SHALL move the FSM to RUN on the next edge, and SHALL clear word_cnt, err_cnt, err_sat and the delay line on that same edge.
REQ-018 RUN SHALL hold clk_enable=1 for exactly FRAME_WORDS cycles, pushing src_word with valid=1 into a LATENCY-deep delay line each cycle, then transition to DRAIN.
REQ-019 DRAIN SHALL hold clk_enable=1 for exactly LATENCY cycles, pushing valid=0 entries, then transition to DONE.
REQ-020 Total clk_enable-high cycles per frame SHALL be FRAME_WORDS+LATENCY.
REQ-021 In any cycle with clk_enable=1 and delay-line output valid=1, the block SHALL add popcount(delayed_word XOR dec_word), in the range 0..WORD_W, to err_cnt and increment word_cnt by 1.
REQ-022 DONE SHALL last one cycle with done=1 and clk_enable=0, then return to IDLE.
REQ-023 word_cnt and err_cnt SHALL hold their final values in IDLE until the next accepted start.
REQ-024 abort=1 in RUN or DRAIN SHALL force IDLE on the next edge with clk_enable=0 and no done pulse; counters SHALL freeze at their values at that point.
REQ-025 If start and abort are high together in IDLE, abort SHALL win and the start SHALL be ignored.
REQ-026 A start pulse outside IDLE SHALL be ignored.
REQ-027 clk_enable SHALL be driven from a register and SHALL NOT pass through a combinational path from any input.

Reset
REQ-028 While reset=0, the FSM SHALL be in IDLE with clk_enable=0, busy=0, done=0, word_cnt=0, err_cnt=0, err_sat=0, and all delay-line valid bits at 0.
REQ-029 Reset asserted mid-frame SHALL take effect immediately and asynchronously; no done pulse SHALL follow.

Configuration
REQ-030 With macro ERR_SATURATE_EN defined, err_cnt SHALL clamp at 32'hFFFF_FFFF and err_sat SHALL set and stay set until the next start or reset.
REQ-031 Without ERR_SATURATE_EN, err_cnt SHALL wrap modulo 2^32 and err_sat SHALL be tied to 0.

Structure
REQ-032 Package conv_viterbi_pkg SHALL hold WORD_W, the FSM state enumeration and the counter width constant (32).
REQ-033 The delay line SHALL be a separate sub-module, word_delay_line (parameters DEPTH and WIDTH; data plus valid shift register; shifts only when enabled; synchronous clear).
REQ-034 The popcount SHALL be a function in conv_viterbi_pkg, not a separate module.

Verification
REQ-035 Bench SHALL cover, with FRAME_WORDS=8 and LATENCY=4 throughout:
- Loopback, dec_word = src_word delayed 4 enabled cycles -> 12 enable cycles, done 1 cycle after the last enable, word_cnt=8, err_cnt=0.
- dec_word = delayed src_word XOR 16'h0003 -> err_cnt=16, word_cnt=8.
- abort asserted on the 5th RUN cycle -> clk_enable low next cycle, no done, busy=0, counters frozen.
- start pulsed during RUN -> ignored; the frame still ends after exactly 12 enable cycles.
- reset driven low during DRAIN -> all outputs zero immediately; a subsequent start runs a clean frame.
- ERR_SATURATE_EN defined, err_cnt forced near max, all-ones error pattern -> err_cnt=32'hFFFF_FFFF and err_sat=1; without the macro -> err_cnt wraps and err_sat=0.
